// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control block: FSM state encoding,
// state width and the default prescaler division.
package stopwatch_pkg;

  localparam int STATE_W      = 2;
  localparam int DEF_TICK_DIV = 250000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// Single-bit rising-edge detector for an already synchronised button level.
// The first cycle after reset is masked so a button held through reset gives no event.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_edge
);

  logic r_btn_q;
  logic r_armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_q <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_btn_q <= i_btn;
      r_armed <= 1'b1;
    end
  end

  assign o_edge = i_btn & ~r_btn_q & r_armed;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause FSM, count-tick prescaler, clear pulse and lap freeze.
// Lap support is built only when STOPWATCH_LAP_EN is defined; otherwise lap_hold is 0.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int DIV_W    = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_start_stop,
  input  logic               btn_clear,
  input  logic               btn_lap,
  input  logic               at_max,
  output logic               tick,
  output logic               count_clr,
  output logic               running,
  output logic               lap_hold,
  output logic [STATE_W-1:0] state
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_count_clr;
  logic             w_ss_ev;
  logic             w_clr_ev;
  logic             w_div_last;
  logic             w_auto_stop;

  btn_edge u_ss_edge (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_start_stop),
    .o_edge (w_ss_ev)
  );

  btn_edge u_clr_edge (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_clear),
    .o_edge (w_clr_ev)
  );

  assign w_div_last  = (r_div_cnt == DIV_LAST);
  // The tick that would overflow the counter chain becomes the stop condition.
  assign w_auto_stop = (r_state == ST_RUN) & w_div_last & at_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_div_cnt   <= '0;
      r_count_clr <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div_cnt   <= w_div_nxt;
      r_count_clr <= w_clr_ev;
    end
  end

  // Clear beats start/stop; start/stop in RUN beats the auto-stop.
  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_ev) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_ss_ev) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (w_ss_ev)          w_state_nxt = ST_PAUSED;
          else if (w_auto_stop) w_state_nxt = ST_DONE;
        end
        ST_PAUSED: if (w_ss_ev) w_state_nxt = ST_RUN;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // Prescaler keeps its phase while paused and restarts from 0 otherwise.
  always_comb begin
    w_div_nxt = '0;
    if (!w_clr_ev) begin
      case (r_state)
        ST_RUN:    w_div_nxt = w_div_last ? '0 : r_div_cnt + 1'b1;
        ST_PAUSED: w_div_nxt = r_div_cnt;
        default:   w_div_nxt = '0;
      endcase
    end
  end

  always_comb begin
    tick      = (r_state == ST_RUN) & w_div_last & ~at_max;
    running   = (r_state == ST_RUN);
    count_clr = r_count_clr;
    state     = r_state;
  end

`ifdef STOPWATCH_LAP_EN
  logic w_lap_ev;
  logic r_lap_hold;
  logic w_lap_nxt;

  btn_edge u_lap_edge (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_lap),
    .o_edge (w_lap_ev)
  );

  // A lap press loses to clear and start/stop in the same cycle.
  always_comb begin
    w_lap_nxt = r_lap_hold;
    if (w_clr_ev) begin
      w_lap_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!w_ss_ev) begin
            if (w_auto_stop)   w_lap_nxt = 1'b0;
            else if (w_lap_ev) w_lap_nxt = ~r_lap_hold;
          end
        end
        ST_PAUSED: if (!w_ss_ev && w_lap_ev) w_lap_nxt = 1'b0;
        default:   w_lap_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_lap_hold <= 1'b0;
    else       r_lap_hold <= w_lap_nxt;
  end

  assign lap_hold = r_lap_hold;
`else
  logic w_unused_lap;
  assign w_unused_lap = btn_lap;
  assign lap_hold     = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4; expected tick cycles are
// queued when a start/resume is driven and matched by a tick monitor.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
`ifdef STOPWATCH_LAP_EN
  localparam logic LAP_EN = 1'b1;
`else
  localparam logic LAP_EN = 1'b0;
`endif
  localparam logic [2:0] P_CLR = 3'b100;
  localparam logic [2:0] P_SS  = 3'b010;
  localparam logic [2:0] P_LAP = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap = 1'b0;
  logic       at_max = 1'b0;
  logic       tick;
  logic       count_clr;
  logic       running;
  logic       lap_hold;
  logic [1:0] state;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          k;
  logic [31:0] exp_q[$];

  stopwatch_ctrl #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .btn_lap        (btn_lap),
    .at_max         (at_max),
    .tick           (tick),
    .count_clr      (count_clr),
    .running        (running),
    .lap_hold       (lap_hold),
    .state          (state)
  );

  // Clock and cycle index.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one-cycle button pulses: bit2 clear, bit1 start/stop, bit0 lap.
  task automatic press(input logic [2:0] m);
    btn_clear      = m[2];
    btn_start_stop = m[1];
    btn_lap        = m[0];
    adv(1);
    btn_clear      = 1'b0;
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
  endtask

  task automatic expect_ticks(input int base, input int n);
    for (int i = 1; i <= n; i++) exp_q.push_back(32'(base + TICK_DIV * i));
  endtask

  // Scoreboard: every tick must match the head of the expected queue.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0] < 32'(cyc)) begin
      check("tick_missing", 32'(cyc), exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (tick) begin
      if (exp_q.size() == 0) check("tick_unexpected", 32'(tick), 32'd0);
      else                   check("tick_time", 32'(cyc), exp_q.pop_front());
    end
  end

  initial begin
    btn_start_stop = 1'b1;
    adv(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_count_clr", 32'(count_clr), 32'd0);
    check("rst_lap_hold", 32'(lap_hold), 32'd0);
    reset = 1'b0;
    adv(3);
    check("held_btn_idle", 32'(state), 32'd0);
    btn_start_stop = 1'b0;
    adv(2);

    // Start: ticks at +4, +8, +12 from the edge cycle.
    k = cyc;
    expect_ticks(k, 3);
    press(P_SS);
    check("start_state", 32'(state), 32'd1);
    check("start_running", 32'(running), 32'd1);
    adv(13);
    press(P_SS);
    check("pause_state", 32'(state), 32'd2);
    check("pause_running", 32'(running), 32'd0);
    adv(10);
    k = cyc;
    exp_q.push_back(32'(k + 2));
    press(P_SS);
    check("resume_state", 32'(state), 32'd1);
    adv(3);

    // Clear and start/stop together while running.
    press(P_SS | P_CLR);
    check("clr_state", 32'(state), 32'd0);
    check("clr_count_clr", 32'(count_clr), 32'd1);
    check("clr_running", 32'(running), 32'd0);
    adv(1);
    check("clr_pulse_end", 32'(count_clr), 32'd0);
    check("clr_state_hold", 32'(state), 32'd0);
    adv(2);

    // Lap toggling while ticks continue, then auto-stop at maximum.
    k = cyc;
    expect_ticks(k, 3);
    press(P_SS);
    press(P_LAP);
    check("lap_set", 32'(lap_hold), 32'(LAP_EN));
    check("lap_run", 32'(state), 32'd1);
    adv(4);
    press(P_LAP);
    check("lap_clear", 32'(lap_hold), 32'd0);
    adv(6);
    press(P_LAP);
    check("lap_set2", 32'(lap_hold), 32'(LAP_EN));
    at_max = 1'b1;
    adv(2);
    check("max_still_run", 32'(state), 32'd1);
    adv(1);
    check("done_state", 32'(state), 32'd3);
    check("done_running", 32'(running), 32'd0);
    check("done_lap_hold", 32'(lap_hold), 32'd0);
    press(P_SS);
    check("done_ignore_ss", 32'(state), 32'd3);
    press(P_LAP);
    check("done_ignore_lap", 32'(lap_hold), 32'd0);
    check("done_state_hold", 32'(state), 32'd3);
    adv(4);
    at_max = 1'b0;
    press(P_CLR);
    check("done_clr_state", 32'(state), 32'd0);
    check("done_clr_pulse", 32'(count_clr), 32'd1);
    adv(2);

    // Synchronous reset in the middle of a run.
    press(P_SS);
    adv(1);
    check("pre_reset_running", 32'(running), 32'd1);
    reset = 1'b1;
    adv(1);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_count_clr", 32'(count_clr), 32'd0);
    reset = 1'b0;
    adv(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
